// File: rtl/pipe_scroll_ctrl_pkg.sv
// Shared types and screen geometry for the pipe scroller.
// Pure declarations plus a gap-pick helper; no state.
package pipe_scroll_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pipe_st_t;

    localparam int PIPE_W   = 64;
    localparam int SCREEN_W = 640;

    // Bump a repeated candidate so two consecutive pipes never share a gap.
    function automatic logic [1:0] pick_gap(input logic [1:0] cand, input logic [1:0] cur);
        return (cand == cur) ? cand + 2'd1 : cand;
    endfunction

endpackage

// File: rtl/pipe_scroll_ctrl_if.sv
// Control/status bundle between game FSM, video sync and the pipe sprite unit.
// master = stimulus side (game FSM / sync), slave = pipe_scroll_ctrl.
interface pipe_scroll_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic        halt;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [4:0]  ctrl;
    logic        active;
    logic        score_tick;
    logic [2:0]  speed;

    modport master (
        output frame_tick, start, halt,
        input  x0, y0, ctrl, active, score_tick, speed
    );

    modport slave (
        input  frame_tick, start, halt,
        output x0, y0, ctrl, active, score_tick, speed
    );
endinterface

// File: rtl/pipe_scroll_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 7,5,4,3) used for gap selection.
// Advances every clock in all states; no backpressure.
module pipe_scroll_ctrl_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/pipe_scroll_ctrl.sv
// Scrolls one pipe left per frame, respawns it with a fresh gap, scores and speeds up.
// frame_tick -> x0/score_tick in 1 clk; inputs are sampled every cycle, no backpressure.
module pipe_scroll_ctrl
    import pipe_scroll_ctrl_pkg::*;
#(
    parameter int         X_START     = SCREEN_W,
    parameter int         SCORE_X     = 40,
    parameter int         MAX_SPEED   = 4,
    parameter int         SPEEDUP_PTS = 5,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    pipe_scroll_ctrl_if.slave  bus
);

    localparam logic [10:0] XS       = 11'(X_START);
    localparam logic [10:0] SX       = 11'(SCORE_X);
    localparam logic [2:0]  SMAX     = 3'(MAX_SPEED);
    localparam logic [7:0]  PTS_LAST = 8'(SPEEDUP_PTS - 1);

    pipe_st_t    st_q, st_d;
    logic [10:0] x0_q, x0_d;
    logic [1:0]  gap_q, gap_d;
    logic [2:0]  spd_q, spd_d;
    logic [7:0]  pts_q, pts_d;
    logic        score_q, score_d;
    logic [7:0]  lfsr_q;
    logic [10:0] x_sub;
    logic [1:0]  new_gap;
    logic        lfsr_unused;

    pipe_scroll_ctrl_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[7:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= IDLE;
            x0_q    <= XS;
            gap_q   <= 2'd0;
            spd_q   <= 3'd1;
            pts_q   <= 8'd0;
            score_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            x0_q    <= x0_d;
            gap_q   <= gap_d;
            spd_q   <= spd_d;
            pts_q   <= pts_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        x0_d    = x0_q;
        gap_d   = gap_q;
        spd_d   = spd_q;
        pts_d   = pts_q;
        score_d = 1'b0;
        x_sub   = x0_q - {8'd0, spd_q};
        new_gap = pick_gap(lfsr_q[1:0], gap_q);

        case (st_q)
            IDLE: begin
                x0_d = XS;
                if (bus.start) begin
                    st_d  = RUN;
                    spd_d = 3'd1;
                    pts_d = 8'd0;
                    gap_d = new_gap;
                end
            end
            RUN: begin
                // halt outranks a same-cycle frame_tick: no move, no score
                if (bus.halt) begin
                    st_d = HALT;
                end else if (bus.frame_tick) begin
                    if (x0_q < {8'd0, spd_q}) begin
                        x0_d  = XS;
                        gap_d = new_gap;
                    end else begin
                        x0_d = x_sub;
                        if (x0_q > SX && x_sub <= SX) begin
                            score_d = 1'b1;
                            if (pts_q == PTS_LAST) begin
                                pts_d = 8'd0;
                                if (spd_q < SMAX) spd_d = spd_q + 3'd1;
                            end else begin
                                pts_d = pts_q + 8'd1;
                            end
                        end
                    end
                end
            end
            HALT: begin
                if (bus.start && !bus.halt) begin
                    st_d  = RUN;
                    x0_d  = XS;
                    spd_d = 3'd1;
                    pts_d = 8'd0;
                    gap_d = new_gap;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign bus.x0         = x0_q;
    assign bus.y0         = 11'd0;
    assign bus.ctrl       = {3'b000, gap_q};
    assign bus.active     = (st_q == RUN);
    assign bus.score_tick = score_q;
    assign bus.speed      = spd_q;

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Directed bench for pipe_scroll_ctrl: vector table plus multi-cycle scroll/score/reset sequences.
module tb_pipe_scroll_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] m_lfsr;
    logic [7:0] pre_lfsr;

    always #5 clk = ~clk;

    pipe_scroll_ctrl_if bus ();
    pipe_scroll_ctrl_if bus2 ();

    pipe_scroll_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance: odd respawn point and a speed-up on every score so
    // the pipe lands exactly on x0=3 at speed 4.
    pipe_scroll_ctrl #(.X_START(651), .SPEEDUP_PTS(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [1:0] exp_gap(input logic [7:0] l, input logic [1:0] old);
        return (l[1:0] == old) ? l[1:0] + 2'd1 : l[1:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive for one clock edge, then sample 1 time unit after it.
    task automatic step(input logic ft, input logic st, input logic ht);
        bus.frame_tick = ft;
        bus.start      = st;
        bus.halt       = ht;
        pre_lfsr       = m_lfsr;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
    endtask

    typedef struct packed {
        logic        ft;
        logic        st;
        logic        ht;
        logic [10:0] x0;
        logic        act;
        logic        sc;
        logic [2:0]  spd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         score_seen;
        int         got;
        logic [1:0] old;
        logic [7:0] lfsr_exp [4];

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 11'd640, 1'b0, 1'b0, 3'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 11'd640, 1'b0, 1'b0, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 11'd640, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 11'd639, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 11'd638, 1'b1, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 11'd638, 1'b1, 1'b0, 3'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 11'd637, 1'b1, 1'b0, 3'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 11'd637, 1'b0, 1'b0, 3'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 11'd637, 1'b0, 1'b0, 3'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 11'd637, 1'b0, 1'b0, 3'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 11'd640, 1'b1, 1'b0, 3'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 11'd639, 1'b1, 1'b0, 3'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 11'd639, 1'b1, 1'b0, 3'd1};
        lfsr_exp[0] = 8'h4A;
        lfsr_exp[1] = 8'h95;
        lfsr_exp[2] = 8'h2A;
        lfsr_exp[3] = 8'h54;

        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.halt = 1'b0;
        bus2.frame_tick = 1'b0; bus2.start = 1'b0; bus2.halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x0", bus.x0, 640);
        chk("rst_ctrl", bus.ctrl, 0);
        chk("rst_speed", bus.speed, 1);
        chk("rst_active", bus.active, 0);
        chk("rst_y0", bus.y0, 0);
        reset = 1'b0;

        // Idle: frame ticks must not move or score the pipe.
        score_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.score_tick) score_seen++;
        end
        chk("idle_x0", bus.x0, 640);
        chk("idle_active", bus.active, 0);
        chk("idle_ctrl", bus.ctrl, 0);
        chk("idle_speed", bus.speed, 1);
        chk("idle_no_score", score_seen, 0);

        for (int v = 0; v < 13; v++) begin
            step(tbl[v].ft, tbl[v].st, tbl[v].ht);
            chk($sformatf("vec%0d_x0", v), bus.x0, tbl[v].x0);
            chk($sformatf("vec%0d_active", v), bus.active, tbl[v].act);
            chk($sformatf("vec%0d_score", v), bus.score_tick, tbl[v].sc);
            chk($sformatf("vec%0d_speed", v), bus.speed, tbl[v].spd);
        end

        // Score crossing at SCORE_X=40 with speed 1.
        for (int i = 0; i < 700 && bus.x0 != 11'd41; i++) step(1'b1, 1'b0, 1'b0);
        chk("reach_41", bus.x0, 41);
        step(1'b1, 1'b0, 1'b0);
        chk("score_x0", bus.x0, 40);
        chk("score_pulse", bus.score_tick, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("score_one_clk", bus.score_tick, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("post_score_x0", bus.x0, 39);
        chk("post_score_pulse", bus.score_tick, 0);

        // Respawn with a fresh gap.
        for (int i = 0; i < 100 && bus.x0 != 11'd0; i++) step(1'b1, 1'b0, 1'b0);
        chk("reach_0", bus.x0, 0);
        old = bus.ctrl[1:0];
        step(1'b1, 1'b0, 1'b0);
        chk("respawn_x0", bus.x0, 640);
        chk("respawn_gap", bus.ctrl[1:0], exp_gap(pre_lfsr, old));
        chk("respawn_gap_new", int'(bus.ctrl[1:0] != old), 1);
        chk("respawn_ctrl_hi", bus.ctrl[4:2], 0);
        chk("respawn_no_score", bus.score_tick, 0);

        // Scores 2..20: speed steps every 5 scores, saturating at 4.
        for (int s = 2; s <= 20; s++) begin
            got = 0;
            for (int i = 0; i < 2000 && got == 0; i++) begin
                step(1'b1, 1'b0, 1'b0);
                got = int'(bus.score_tick);
            end
            chk($sformatf("score%0d_seen", s), got, 1);
            chk($sformatf("score%0d_x0", s), bus.x0, 40);
            chk($sformatf("score%0d_speed", s), bus.speed, (1 + s / 5 > 4) ? 4 : 1 + s / 5);
        end
        for (int i = 0; i < 100 && bus.x0 != 11'd0; i++) step(1'b1, 1'b0, 1'b0);
        chk("spd4_reach_0", bus.x0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("spd4_respawn", bus.x0, 640);

        // x0=3 at speed 4 must respawn rather than subtract.
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        bus2.frame_tick = 1'b1;
        for (int i = 0; i < 3000 && !(bus2.x0 == 11'd3 && bus2.speed == 3'd4); i++) begin
            @(posedge clk); #1;
        end
        chk("d2_reach_3", bus2.x0, 3);
        chk("d2_speed", bus2.speed, 4);
        @(posedge clk); #1;
        bus2.frame_tick = 1'b0;
        chk("d2_respawn", bus2.x0, 651);

        // Halt and frame_tick together at x0=300.
        for (int i = 0; i < 200 && bus.x0 != 11'd300; i++) step(1'b1, 1'b0, 1'b0);
        chk("reach_300", bus.x0, 300);
        step(1'b1, 1'b0, 1'b1);
        chk("halt_x0", bus.x0, 300);
        chk("halt_active", bus.active, 0);
        chk("halt_score", bus.score_tick, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("halt_tick_ignored", bus.x0, 300);
        step(1'b0, 1'b1, 1'b1);
        chk("halt_start_halt", bus.active, 0);
        chk("halt_start_halt_x0", bus.x0, 300);
        old = bus.ctrl[1:0];
        step(1'b0, 1'b1, 1'b0);
        chk("restart_active", bus.active, 1);
        chk("restart_x0", bus.x0, 640);
        chk("restart_speed", bus.speed, 1);
        chk("restart_gap", bus.ctrl[1:0], exp_gap(pre_lfsr, old));

        // Asynchronous reset mid-run at x0=123.
        for (int i = 0; i < 700 && bus.x0 != 11'd123; i++) step(1'b1, 1'b0, 1'b0);
        chk("reach_123", bus.x0, 123);
        reset = 1'b1;
        #2;
        chk("arst_x0", bus.x0, 640);
        chk("arst_ctrl", bus.ctrl, 0);
        chk("arst_score", bus.score_tick, 0);
        chk("arst_active", bus.active, 0);
        chk("arst_speed", bus.speed, 1);
        @(posedge clk); #1;
        chk("lfsr_seed", dut.u_lfsr.q, 8'hA5);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lfsr_step%0d", k + 1), dut.u_lfsr.q, lfsr_exp[k]);
        end
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lfsr_model%0d", k), dut.u_lfsr.q, m_lfsr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
